butterfly_pipe: RTL and testbench

- Parametrised, pipelined radix-2 DIT butterfly. Next generation of butterfly_unit.
- Computes A' = A + B·W and B' = A − B·W on signed fixed-point complex samples.
- Adds configurable data and twiddle widths, valid/ready flow control, per-beat divide-by-2 scaling, rounding, and saturation with overflow flags.
- Instantiated once per FFT stage, between the stage's sample buffer and the twiddle ROM.

---
 rtl/butterfly_pipe_if.sv | 38 +++
 rtl/butterfly_pipe.sv | 143 ++++++++++++++
 tb/tb_butterfly_pipe.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/butterfly_pipe_if.sv
// Streaming port bundle for butterfly_pipe: input beat (A, B, W, scale) with
// valid/ready, and output beat (A', B', overflow flags) with valid/ready.
interface butterfly_pipe_if #(
  parameter int DW = 16,
  parameter int TW = 16
);
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] i_data_ra;
  logic [DW-1:0] i_data_ca;
  logic [DW-1:0] i_data_rb;
  logic [DW-1:0] i_data_cb;
  logic [TW-1:0] i_twiddle_r;
  logic [TW-1:0] i_twiddle_c;
  logic          i_scale;
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data_ra;
  logic [DW-1:0] o_data_ca;
  logic [DW-1:0] o_data_rb;
  logic [DW-1:0] o_data_cb;
  logic          o_ovf;
  logic          o_ovf_sticky;

  modport master (
    output i_valid, i_data_ra, i_data_ca, i_data_rb, i_data_cb,
           i_twiddle_r, i_twiddle_c, i_scale, o_ready,
    input  i_ready, o_valid, o_data_ra, o_data_ca, o_data_rb, o_data_cb,
           o_ovf, o_ovf_sticky
  );

  modport slave (
    input  i_valid, i_data_ra, i_data_ca, i_data_rb, i_data_cb,
           i_twiddle_r, i_twiddle_c, i_scale, o_ready,
    output i_ready, o_valid, o_data_ra, o_data_ca, o_data_rb, o_data_cb,
           o_ovf, o_ovf_sticky
  );
endinterface

// File: rtl/butterfly_pipe.sv
// Three-stage pipelined radix-2 DIT butterfly: A' = A + B*W, B' = A - B*W,
// with optional per-beat halving, round half-up, saturation and overflow flags.
module butterfly_pipe #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  butterfly_pipe_if.slave bus
);
  localparam int PW = DW + TW;
  localparam int FW = PW + 1;
  localparam int QW = DW + 2;
  localparam int SW = DW + 3;

  localparam logic signed [FW-1:0] RND  = FW'(1) << (TW - 3);
  localparam logic signed [SW-1:0] ONE  = SW'(1);
  localparam logic signed [SW-1:0] MAXV = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // One enable for every stage: bubbles are held in place, never collapsed.
  logic en;
  assign en          = bus.o_ready | ~bus.o_valid;
  assign bus.i_ready = en;

  logic signed [DW-1:0] br, bc;
  logic signed [TW-1:0] wr, wc;
  logic signed [PW-1:0] m_rr, m_cc, m_rc, m_cr;

  assign br   = $signed(bus.i_data_rb);
  assign bc   = $signed(bus.i_data_cb);
  assign wr   = $signed(bus.i_twiddle_r);
  assign wc   = $signed(bus.i_twiddle_c);
  assign m_rr = PW'(br) * PW'(wr);
  assign m_cc = PW'(bc) * PW'(wc);
  assign m_rc = PW'(br) * PW'(wc);
  assign m_cr = PW'(bc) * PW'(wr);

  logic                 s1_valid, s1_scale;
  logic signed [PW-1:0] s1_rr, s1_cc, s1_rc, s1_cr;
  logic signed [DW-1:0] s1_ar, s1_ac;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_scale <= 1'b0;
      s1_rr    <= '0;
      s1_cc    <= '0;
      s1_rc    <= '0;
      s1_cr    <= '0;
      s1_ar    <= '0;
      s1_ac    <= '0;
    end else if (en) begin
      s1_valid <= bus.i_valid;
      s1_scale <= bus.i_scale;
      s1_rr    <= m_rr;
      s1_cc    <= m_cc;
      s1_rc    <= m_rc;
      s1_cr    <= m_cr;
      s1_ar    <= $signed(bus.i_data_ra);
      s1_ac    <= $signed(bus.i_data_ca);
    end
  end

  // Complex product with the rounding offset folded in before the shift.
  logic signed [FW-1:0] pr_full, pi_full;
  assign pr_full = FW'(s1_rr) - FW'(s1_cc) + RND;
  assign pi_full = FW'(s1_rc) + FW'(s1_cr) + RND;

  logic                 s2_valid, s2_scale;
  logic signed [QW-1:0] s2_pr, s2_pi;
  logic signed [DW-1:0] s2_ar, s2_ac;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_scale <= 1'b0;
      s2_pr    <= '0;
      s2_pi    <= '0;
      s2_ar    <= '0;
      s2_ac    <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_scale <= s1_scale;
      s2_pr    <= QW'(pr_full >>> (TW - 2));
      s2_pi    <= QW'(pi_full >>> (TW - 2));
      s2_ar    <= s1_ar;
      s2_ac    <= s1_ac;
    end
  end

  // Returns {clipped, value}: optional halving with round half-up, then clamp.
  function automatic logic [DW:0] finish_val(input logic signed [SW-1:0] v,
                                             input logic scale);
    logic signed [SW-1:0] t;
    logic [DW:0]          res;
    t = v;
    if (scale) t = (v + ONE) >>> 1;
    if (t > MAXV)      res = {1'b1, MAXV[DW-1:0]};
    else if (t < MINV) res = {1'b1, MINV[DW-1:0]};
    else               res = {1'b0, DW'(t)};
    return res;
  endfunction

  logic signed [SW-1:0] sr, si, dr, di;
  logic [DW:0]          f_sr, f_si, f_dr, f_di;
  logic                 ovf_next;

  always_comb begin
    sr       = SW'(s2_ar) + SW'(s2_pr);
    si       = SW'(s2_ac) + SW'(s2_pi);
    dr       = SW'(s2_ar) - SW'(s2_pr);
    di       = SW'(s2_ac) - SW'(s2_pi);
    f_sr     = finish_val(sr, s2_scale);
    f_si     = finish_val(si, s2_scale);
    f_dr     = finish_val(dr, s2_scale);
    f_di     = finish_val(di, s2_scale);
    ovf_next = f_sr[DW] | f_si[DW] | f_dr[DW] | f_di[DW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_valid      <= 1'b0;
      bus.o_data_ra    <= '0;
      bus.o_data_ca    <= '0;
      bus.o_data_rb    <= '0;
      bus.o_data_cb    <= '0;
      bus.o_ovf        <= 1'b0;
      bus.o_ovf_sticky <= 1'b0;
    end else if (en) begin
      bus.o_valid <= s2_valid;
      // Bubbles leave the last delivered beat on the outputs.
      if (s2_valid) begin
        bus.o_data_ra    <= f_sr[DW-1:0];
        bus.o_data_ca    <= f_si[DW-1:0];
        bus.o_data_rb    <= f_dr[DW-1:0];
        bus.o_data_cb    <= f_di[DW-1:0];
        bus.o_ovf        <= ovf_next;
        bus.o_ovf_sticky <= bus.o_ovf_sticky | ovf_next;
      end
    end
  end
endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe: hand-derived vector table, random
// backpressure stream against a reference model, latency and mid-stream reset.
module tb_butterfly_pipe;
  localparam int DW = 16;
  localparam int TW = 16;

  typedef struct { int ra, ca, rb, cb, wr, wc; bit scale; } in_t;
  typedef struct { int ra, ca, rb, cb; bit ovf; } out_t;
  typedef struct { in_t i; out_t o; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   bp_en = 1'b0;
  always #5 clk = ~clk;

  butterfly_pipe_if #(.DW(DW), .TW(TW)) bus ();
  butterfly_pipe #(.DW(DW), .TW(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   errors = 0;
  int   checks = 0;
  int   n_out  = 0;
  out_t q[$];
  out_t cur_exp;
  bit   prev_stall = 1'b0;
  int   hold[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [DW-1:0] x);
    return int'($signed(x));
  endfunction

  function automatic out_t model(input in_t v);
    longint pr, pi, rnd, mx, mn;
    longint s[4];
    out_t   r;
    rnd = longint'(1) << (TW - 3);
    mx  = (longint'(1) << (DW - 1)) - 1;
    mn  = -(longint'(1) << (DW - 1));
    pr  = (longint'(v.rb) * v.wr - longint'(v.cb) * v.wc + rnd) >>> (TW - 2);
    pi  = (longint'(v.rb) * v.wc + longint'(v.cb) * v.wr + rnd) >>> (TW - 2);
    s[0] = v.ra + pr; s[1] = v.ca + pi; s[2] = v.ra - pr; s[3] = v.ca - pi;
    r.ovf = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (v.scale) s[k] = (s[k] + 1) >>> 1;
      if (s[k] > mx) begin s[k] = mx; r.ovf = 1'b1; end
      else if (s[k] < mn) begin s[k] = mn; r.ovf = 1'b1; end
    end
    r.ra = int'(s[0]); r.ca = int'(s[1]); r.rb = int'(s[2]); r.cb = int'(s[3]);
    return r;
  endfunction

  // Downstream ready: free-running 1,0,0,1,0,1 pattern when backpressure is on.
  bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int pk = 0;
  initial bus.o_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      bus.o_ready = pat[pk];
      pk = (pk + 1) % 6;
    end else begin
      bus.o_ready = 1'b1;
    end
  end

  // Monitor: scoreboard push on accept, pop on output transfer, stall stability.
  always @(negedge clk) begin
    out_t e;
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("i_ready_rule", int'(bus.i_ready), int'(!(bus.o_valid && !bus.o_ready)));
      if (prev_stall) begin
        chk("stall_valid", int'(bus.o_valid), 1);
        chk("stall_ra", sx(bus.o_data_ra), hold[0]);
        chk("stall_ca", sx(bus.o_data_ca), hold[1]);
        chk("stall_rb", sx(bus.o_data_rb), hold[2]);
        chk("stall_cb", sx(bus.o_data_cb), hold[3]);
        chk("stall_ovf", int'(bus.o_ovf), hold[4]);
      end
      if (bus.o_valid && bus.o_ready) begin
        n_out++;
        if (q.size() == 0) begin
          chk("unexpected_beat", q.size(), 1);
        end else begin
          e = q.pop_front();
          chk("out_ra", sx(bus.o_data_ra), e.ra);
          chk("out_ca", sx(bus.o_data_ca), e.ca);
          chk("out_rb", sx(bus.o_data_rb), e.rb);
          chk("out_cb", sx(bus.o_data_cb), e.cb);
          chk("out_ovf", int'(bus.o_ovf), int'(e.ovf));
        end
      end
      prev_stall = bus.o_valid && !bus.o_ready;
      if (prev_stall) begin
        hold[0] = sx(bus.o_data_ra); hold[1] = sx(bus.o_data_ca);
        hold[2] = sx(bus.o_data_rb); hold[3] = sx(bus.o_data_cb);
        hold[4] = int'(bus.o_ovf);
      end
      if (bus.i_valid && bus.i_ready) q.push_back(cur_exp);
    end
  end

  task automatic drive(input in_t v, input out_t e);
    bit acc = 1'b0;
    bus.i_data_ra   = DW'(v.ra);
    bus.i_data_ca   = DW'(v.ca);
    bus.i_data_rb   = DW'(v.rb);
    bus.i_data_cb   = DW'(v.cb);
    bus.i_twiddle_r = TW'(v.wr);
    bus.i_twiddle_c = TW'(v.wc);
    bus.i_scale     = v.scale;
    cur_exp         = e;
    bus.i_valid     = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = bus.i_ready;
      @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b0;
    chk("accept_timeout", int'(acc), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_o_valid"}, int'(bus.o_valid), 0);
    chk({tag, "_ra"}, sx(bus.o_data_ra), 0);
    chk({tag, "_ca"}, sx(bus.o_data_ca), 0);
    chk({tag, "_rb"}, sx(bus.o_data_rb), 0);
    chk({tag, "_cb"}, sx(bus.o_data_cb), 0);
    chk({tag, "_ovf"}, int'(bus.o_ovf), 0);
    chk({tag, "_sticky"}, int'(bus.o_ovf_sticky), 0);
  endtask

  vec_t tbl[8];
  in_t  t1;
  out_t t1_exp;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t v;
    int  n0;
    t1     = '{ra: 5, ca: 6, rb: 10, cb: 3, wr: 16384, wc: 0, scale: 1'b0};
    t1_exp = '{ra: 15, ca: 9, rb: -5, cb: 3, ovf: 1'b0};
    tbl[0] = '{i: t1, o: t1_exp};
    tbl[1] = '{i: '{5, 6, 10, 3, 0, -16384, 1'b0},   o: '{8, -4, 2, 16, 1'b0}};
    tbl[2] = '{i: '{5, 6, 10, 3, 16384, 0, 1'b1},    o: '{8, 5, -2, 2, 1'b0}};
    tbl[3] = '{i: '{-100, 200, 300, -400, 11585, 11585, 1'b0}, o: '{395, 129, -595, 271, 1'b0}};
    tbl[4] = '{i: '{32767, 0, 1, 0, 16384, 0, 1'b0}, o: '{32767, 0, 32766, 0, 1'b1}};
    tbl[5] = '{i: '{-32768, 0, 1, 0, 16384, 0, 1'b0}, o: '{-32767, 0, -32768, 0, 1'b1}};
    tbl[6] = '{i: '{32767, 0, -32768, 0, -16384, 0, 1'b0}, o: '{32767, 0, -1, 0, 1'b1}};
    tbl[7] = '{i: t1, o: t1_exp};

    bus.i_valid = 1'b0; bus.i_scale = 1'b0;
    bus.i_data_ra = '0; bus.i_data_ca = '0; bus.i_data_rb = '0; bus.i_data_cb = '0;
    bus.i_twiddle_r = '0; bus.i_twiddle_c = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(bus.i_ready), 1);
    @(posedge clk); #1;

    // Latency: o_valid rises on the third edge after acceptance.
    drive(t1, t1_exp);
    @(negedge clk); chk("lat_edge1", int'(bus.o_valid), 0);
    @(negedge clk); chk("lat_edge2", int'(bus.o_valid), 0);
    @(negedge clk); chk("lat_edge3", int'(bus.o_valid), 1);
    chk("sticky_clean", int'(bus.o_ovf_sticky), 0);
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) drive(tbl[k].i, tbl[k].o);
    drain();
    @(negedge clk);
    chk("sticky_after_sat", int'(bus.o_ovf_sticky), 1);
    chk("ovf_clean_beat", int'(bus.o_ovf), 0);
    @(posedge clk); #1;

    // Backpressure stream of distinct random beats.
    bp_en = 1'b1;
    n0 = n_out;
    for (int k = 0; k < 6; k++) begin
      v.ra = int'($urandom_range(4000)) - 2000 + k;
      v.ca = int'($urandom_range(4000)) - 2000;
      v.rb = int'($urandom_range(4000)) - 2000;
      v.cb = int'($urandom_range(4000)) - 2000;
      v.wr = int'($urandom_range(32768)) - 16384;
      v.wc = int'($urandom_range(32768)) - 16384;
      v.scale = k[0];
      drive(v, model(v));
    end
    drain();
    chk("bp_beat_count", n_out - n0, 6);
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with three beats in flight.
    for (int k = 1; k < 4; k++) drive(tbl[k].i, tbl[k].o);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    chk("midreset_ready", int'(bus.i_ready), 1);
    @(posedge clk); #1;
    n0 = n_out;
    drive(t1, t1_exp);
    @(negedge clk); chk("post_rst_edge1", int'(bus.o_valid), 0);
    @(negedge clk); chk("post_rst_edge2", int'(bus.o_valid), 0);
    @(negedge clk); chk("post_rst_edge3", int'(bus.o_valid), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_count", n_out - n0, 1);
    chk("final_queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
